// File: rtl/reply_serializer.sv
`default_nettype none
// ============================================================================
// Module   : reply_serializer
// Purpose  : Queues word-wide reply records, streams them LSB-byte-first to host
// Revision : 1.0  initial release
// ============================================================================
module reply_serializer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int LEN_W      = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_data,
   input  logic [LEN_W-1:0]      req_len,
   output logic                  reply_rdy,
   output logic [7:0]            reply,
   input  logic                  reply_ack,
   output logic                  reply_end,
   output logic                  len_err,
   output logic [LEN_W:0]        queue_level
);

   localparam int                c_AW       = $clog2(DEPTH);
   localparam logic [LEN_W-1:0]  c_MAX_LEN  = LEN_W'(DATA_WIDTH / 8);
   localparam logic [LEN_W-1:0]  c_LEN_ZERO = '0;
   localparam logic [LEN_W-1:0]  c_LEN_ONE  = LEN_W'(1);
   localparam logic [LEN_W-1:0]  c_LEN_TWO  = LEN_W'(2);
   localparam logic [c_AW:0]     c_PTR_ONE  = (c_AW + 1)'(1);
   localparam logic [LEN_W:0]    c_LVL_ONE  = (LEN_W + 1)'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
   logic [LEN_W-1:0]      r_mem_len  [DEPTH];
   logic [c_AW:0]         r_wr_ptr;
   logic [c_AW:0]         r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_sr;
   logic [LEN_W-1:0]      r_cnt;
   logic [LEN_W:0]        r_level;
   logic                  r_len_err;
   logic                  r_reply_rdy;
   logic                  r_reply_end;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_accept;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_last;
   logic [LEN_W-1:0]      w_len_clamped;
   logic [DATA_WIDTH-1:0] w_head_data;
   logic [LEN_W-1:0]      w_head_len;
   logic [DATA_WIDTH-1:0] w_sr_next;

   assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_accept = req_valid && !w_full;
   // Zero-length records are acknowledged to the handler but never stored.
   assign w_push   = w_accept && (req_len != c_LEN_ZERO);
   assign w_len_clamped = (req_len > c_MAX_LEN) ? c_MAX_LEN : req_len;

   assign w_head_data = r_mem_data[r_rd_ptr[c_AW-1:0]];
   assign w_head_len  = r_mem_len[r_rd_ptr[c_AW-1:0]];
   assign w_sr_next   = r_sr >> 8;

   // Popping on the final acknowledged byte lets records run back to back.
   assign w_last = (r_state == ST_SEND) && reply_ack && (r_cnt == c_LEN_ONE);
   assign w_pop  = !w_empty && ((r_state == ST_IDLE) || w_last);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr[c_AW-1:0]] <= req_data;
         r_mem_len[r_wr_ptr[c_AW-1:0]]  <= w_len_clamped;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_level   <= '0;
         r_len_err <= 1'b0;
      end else begin
         r_len_err <= w_accept && (req_len == c_LEN_ZERO);
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + c_LVL_ONE;
            2'b01:   r_level <= r_level - c_LVL_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_sr        <= '0;
         r_cnt       <= '0;
         r_reply_rdy <= 1'b0;
         r_reply_end <= 1'b0;
      end else if (w_pop) begin
         r_state     <= ST_SEND;
         r_sr        <= w_head_data;
         r_cnt       <= w_head_len;
         r_reply_rdy <= 1'b1;
         r_reply_end <= (w_head_len == c_LEN_ONE);
      end else begin
         case (r_state)
            ST_SEND: begin
               if (reply_ack) begin
                  if (r_cnt != c_LEN_ONE) begin
                     r_sr        <= w_sr_next;
                     r_cnt       <= r_cnt - c_LEN_ONE;
                     r_reply_end <= (r_cnt == c_LEN_TWO);
                  end else begin
                     r_state     <= ST_IDLE;
                     r_sr        <= '0;
                     r_cnt       <= '0;
                     r_reply_rdy <= 1'b0;
                     r_reply_end <= 1'b0;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready   = !w_full;
   assign reply_rdy   = r_reply_rdy;
   assign reply       = r_sr[7:0];
   assign reply_end   = r_reply_end;
   assign len_err     = r_len_err;
   assign queue_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_reply_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reply_serializer
// Purpose  : Directed and random checks of reply_serializer against a byte queue
// Revision : 1.0  initial release
// ============================================================================
module tb_reply_serializer;

   localparam int DATA_WIDTH = 32;
   localparam int DEPTH      = 4;
   localparam int LEN_W      = 3;
   localparam int NBYTES     = DATA_WIDTH / 8;

   logic                  clk;
   logic                  reset;
   logic                  req_valid;
   logic                  req_ready;
   logic [DATA_WIDTH-1:0] req_data;
   logic [LEN_W-1:0]      req_len;
   logic                  reply_rdy;
   logic [7:0]            reply;
   logic                  reply_ack;
   logic                  reply_end;
   logic                  len_err;
   logic [LEN_W:0]        queue_level;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected byte stream: {last_of_record, byte}
   logic [8:0] exp_q[$];
   bit         exp_len_err = 1'b0;

   reply_serializer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_len(req_len),
      .reply_rdy(reply_rdy), .reply(reply), .reply_ack(reply_ack),
      .reply_end(reply_end), .len_err(len_err), .queue_level(queue_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic model_push(input logic [DATA_WIDTH-1:0] d, input logic [LEN_W-1:0] l);
      int n;
      n = (int'(l) > NBYTES) ? NBYTES : int'(l);
      for (int i = 0; i < n; i++)
         exp_q.push_back({(i == n - 1), d[8*i +: 8]});
   endtask

   task automatic model_flush();
      exp_q.delete();
      exp_len_err = 1'b0;
   endtask

   // Scoreboard: every offered byte must be the model's head byte.
   always @(negedge clk) begin
      if (!reset) begin
         check("len_err", len_err, exp_len_err);
         exp_len_err = req_valid && req_ready && (req_len == 0);
         if (reply_rdy) begin
            if (exp_q.size() == 0) begin
               check("spurious_rdy", reply_rdy, 0);
            end else begin
               check("byte", reply, exp_q[0][7:0]);
               check("end", reply_end, exp_q[0][8]);
               if (reply_ack) void'(exp_q.pop_front());
            end
         end
         if (req_valid && req_ready && (req_len != 0)) model_push(req_data, req_len);
      end
   end

   task automatic push(input logic [DATA_WIDTH-1:0] d, input logic [LEN_W-1:0] l);
      bit acc;
      acc       = 1'b0;
      req_valid = 1'b1;
      req_data  = d;
      req_len   = l;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      check("push_accepted", acc, 1);
   endtask

   task automatic drain();
      reply_ack = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !reply_rdy) break;
      end
      check("drain_empty", exp_q.size(), 0);
      check("drain_idle", reply_rdy, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b[4];
      reset     = 1'b1;
      req_valid = 1'b0;
      req_data  = '0;
      req_len   = '0;
      reply_ack = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_rdy", reply_rdy, 0);
      check("rst_reply", reply, 8'h00);
      check("rst_end", reply_end, 0);
      check("rst_len_err", len_err, 0);
      check("rst_level", queue_level, 0);
      check("rst_ready", req_ready, 1);
      reset = 1'b0;
      model_flush();

      // Full-word record with ack held: latency and byte order
      reply_ack = 1'b1;
      push(32'hDEADBEEF, 3'd4);
      @(negedge clk);
      check("t1_latency_rdy0", reply_rdy, 0);
      b[0] = 8'hEF; b[1] = 8'hBE; b[2] = 8'hAD; b[3] = 8'hDE;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t1_rdy", reply_rdy, 1);
         check("t1_byte", reply, b[i]);
         check("t1_end", reply_end, (i == 3));
      end
      @(negedge clk);
      check("t1_idle", reply_rdy, 0);
      @(posedge clk);
      #1;

      // Held byte while host stalls
      reply_ack = 1'b0;
      push(32'h00001234, 3'd2);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t2_hold_rdy", reply_rdy, 1);
         check("t2_hold_byte", reply, 8'h34);
         check("t2_hold_end", reply_end, 0);
      end
      @(posedge clk);
      #1 reply_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t2_byte1", reply, 8'h12);
      check("t2_end1", reply_end, 1);
      drain();

      // Fill the queue behind a stalled record
      reply_ack = 1'b0;
      for (int k = 0; k < 5; k++) push(DATA_WIDTH'(32'h0000A000 + k * 32'h0101), 3'd2);
      @(negedge clk);
      check("t3_level_full", queue_level, DEPTH);
      check("t3_ready_low", req_ready, 0);
      @(posedge clk);
      #1 reply_ack = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready) break;
      end
      check("t3_ready_back", req_ready, 1);
      check("t3_level_after_pop", queue_level, DEPTH - 1);
      drain();

      // Back-to-back records, no bubble
      reply_ack = 1'b1;
      push(32'h000000A1, 3'd1);
      push(32'h00C3C2C1, 3'd3);
      b[0] = 8'hA1; b[1] = 8'hC1; b[2] = 8'hC2; b[3] = 8'hC3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t4_rdy", reply_rdy, 1);
         check("t4_byte", reply, b[i]);
         check("t4_end", reply_end, (i == 0 || i == 3));
      end
      drain();

      // Zero length and over-length records
      push(32'h99999999, 3'd0);
      @(negedge clk);
      check("t5_len_err", len_err, 1);
      check("t5_no_rdy", reply_rdy, 0);
      @(posedge clk);
      #1;
      push(32'h44332211, 3'd6);
      @(negedge clk);
      check("t5_len_err_clear", len_err, 0);
      b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t5_byte", reply, b[i]);
         check("t5_end", reply_end, (i == 3));
      end
      drain();

      // Reset in the middle of a record with others queued
      reply_ack = 1'b0;
      push(32'h87654321, 3'd4);
      push(32'h00005555, 3'd2);
      push(32'h00000066, 3'd1);
      reply_ack = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 reply_ack = 1'b0;
      @(negedge clk);
      check("t6_mid_byte", reply, 8'h65);
      check("t6_mid_level", queue_level, 2);
      #1 reset = 1'b1;
      #1;
      check("t6_rst_rdy", reply_rdy, 0);
      check("t6_rst_end", reply_end, 0);
      check("t6_rst_level", queue_level, 0);
      check("t6_rst_ready", req_ready, 1);
      model_flush();
      @(posedge clk);
      #1 reset = 1'b0;
      model_flush();
      reply_ack = 1'b1;
      push(32'h0000BBAA, 3'd2);
      @(negedge clk);
      @(negedge clk);
      check("t6_new_byte0", reply, 8'hAA);
      check("t6_new_end0", reply_end, 0);
      @(negedge clk);
      check("t6_new_byte1", reply, 8'hBB);
      check("t6_new_end1", reply_end, 1);
      drain();

      // Random traffic against the byte-queue model
      for (int c = 0; c < 400; c++) begin
         req_valid = ($urandom % 3) != 0;
         req_data  = $urandom;
         req_len   = LEN_W'($urandom % 8);
         reply_ack = ($urandom % 2) != 0;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
